// File: rtl/neuron_integrate_fire_if.sv
// Row-in / spike-out handshake bundle for neuron_integrate_fire.
// The neuron core drives through the slave modport; producers and consumers use master.
interface neuron_integrate_fire_if #(
  parameter int NUM_NEURONS = 32
);
  logic                   row_valid_i;
  logic                   row_ready_o;
  logic [NUM_NEURONS-1:0] row_conn_i;
  logic [1:0]             row_type_i;
  logic                   spike_valid_o;
  logic                   spike_ready_i;
  logic [NUM_NEURONS-1:0] spike_o;

  modport slave (
    input  row_valid_i, row_conn_i, row_type_i, spike_ready_i,
    output row_ready_o, spike_valid_o, spike_o
  );

  modport master (
    output row_valid_i, row_conn_i, row_type_i, spike_ready_i,
    input  row_ready_o, spike_valid_o, spike_o
  );
endinterface

// File: rtl/neuron_integrate_fire.sv
// Serial integrate-and-fire neuron array: one neuron updated per cycle during INTEG and FIRE.
// Optional macro NEURON_LEAK_EN adds leak_i to every potential on each tick.
module neuron_integrate_fire #(
  parameter int NUM_NEURONS = 32,
  parameter int POT_W       = 9
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  neuron_integrate_fire_if.slave    bus,
  input  logic [4*POT_W-1:0]        weight_i,
  input  logic signed [POT_W-1:0]   leak_i,
  input  logic signed [POT_W-1:0]   threshold_i,
  input  logic signed [POT_W-1:0]   reset_pot_i,
  input  logic                      tick_i,
  output logic                      busy_o,
  output logic                      tick_overrun_o
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, INTEG, FIRE, OUT} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic                    tick_pend;
  logic [NUM_NEURONS-1:0]  conn;
  logic [NUM_NEURONS-1:0]  spike;
  logic signed [POT_W-1:0] w;
  logic signed [POT_W-1:0] pot [NUM_NEURONS];

  // Add at POT_W+1 bits, then clamp to the representable range on overflow.
  function automatic logic signed [POT_W-1:0] sat_add(
    input logic signed [POT_W-1:0] a,
    input logic signed [POT_W-1:0] b
  );
    logic [POT_W:0] s;
    s = {a[POT_W-1], a} + {b[POT_W-1], b};
    if (s[POT_W] != s[POT_W-1])
      sat_add = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
    else
      sat_add = s[POT_W-1:0];
  endfunction

  logic signed [POT_W-1:0] pot_cur;
  logic signed [POT_W-1:0] integ_sum;
  logic signed [POT_W-1:0] fire_v;
  logic signed [POT_W-1:0] w_sel;
  logic                    fires;
  logic                    accept;
  logic                    tick_drop;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    pot_cur   = pot[idx];
    integ_sum = sat_add(pot_cur, w);
`ifdef NEURON_LEAK_EN
    fire_v    = sat_add(pot_cur, leak_i);
`else
    fire_v    = pot_cur;
`endif
    fires     = (fire_v >= threshold_i);
    w_sel     = weight_i[bus.row_type_i*POT_W +: POT_W];
  end

`ifndef NEURON_LEAK_EN
  logic unused_leak;
  assign unused_leak = ^leak_i;
`endif

  // A tick in IDLE has priority over a row offered in the same cycle.
  assign bus.row_ready_o   = (state == IDLE) && !tick_pend && !tick_i;
  assign accept            = bus.row_valid_i && bus.row_ready_o;
  assign tick_drop         = tick_i && (tick_pend || (state == FIRE) || (state == OUT));
  assign bus.spike_valid_o = (state == OUT);
  assign bus.spike_o       = spike;
  assign busy_o            = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state          <= IDLE;
      idx            <= '0;
      tick_pend      <= 1'b0;
      tick_overrun_o <= 1'b0;
      conn           <= '0;
      w              <= '0;
      spike          <= '0;
      // NOTE: potentials must all read zero after reset, so this array is flops, not a RAM.
      for (int i = 0; i < NUM_NEURONS; i++) pot[i] <= '0;
    end else begin
      if (tick_drop) tick_overrun_o <= 1'b1;

      case (state)
        IDLE: begin
          idx <= '0;
          if (tick_i) begin
            state <= FIRE;
          end else if (accept) begin
            conn  <= bus.row_conn_i;
            w     <= w_sel;
            state <= INTEG;
          end
        end

        INTEG: begin
          if (conn[idx]) pot[idx] <= integ_sum;
          if (tick_i) tick_pend <= 1'b1;
          if (idx == LAST_IDX) begin
            idx <= '0;
            if (tick_pend || tick_i) begin
              state     <= FIRE;
              tick_pend <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        FIRE: begin
          spike[idx] <= fires;
          pot[idx]   <= fires ? reset_pot_i : fire_v;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= OUT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        OUT: begin
          if (bus.spike_ready_i) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
